hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Decode-side control stage directly upstream of the register bank block in the 16-bit MIPS pipeline.
- Takes decoded instruction fields and registers RA/RB, imm_sel and the forwarding selects mux_sel_A/mux_sel_B that the register bank consumes.
- Tracks destination registers down the pipe as RW_ex, RW_dm and RW_wb, and stalls fetch/decode one cycle on a load-use hazard.

Parameters:
- REG_W, 5, register address width
- OPC_W, 6, opcode width

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- opcode  in  OPC_W  decoded opcode; class = opcode[5:4]
- ra_in  in  REG_W  source A address
- rb_in  in  REG_W  source B address
- rw_in  in  REG_W  destination address
- stall  out  1  combinational; holds fetch/decode inputs
- out_valid  out  1  reg-bank stage holds a real instruction
- RA  out  REG_W  registered source A to register bank
- RB  out  REG_W  registered source B to register bank
- imm_sel  out  1  registered immediate select
- mux_sel_A  out  2  forwarding select for A: 00 reg file, 01 ans_ex, 10 ans_dm, 11 ans_wb
- mux_sel_B  out  2  forwarding select for B, same encoding
- RW_ex  out  REG_W  destination of instruction in EX (0 if none)
- RW_dm  out  REG_W  destination of instruction in DM (0 if none)
- RW_wb  out  REG_W  destination of instruction in WB (0 if none)
- we_wb  out  1  register-file write enable in WB

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous, active-high. All outputs and internal stage registers reset to 0.
- Instruction classes by opcode[5:4]:
  - 00 R-ALU: uses RA and RB; writes rw.
  - 01 I-ALU: uses RA only; imm_sel=1; writes rw.
  - 10 LOAD: uses RA only; imm_sel=1; writes rw; load flag set.
  - 11 STORE: uses RA and RB; imm_sel=1; no write.
- Internal reg-bank stage holds rw_rb, wr_rb and ld_rb alongside RA/RB.
- Every edge, the pipe shifts: RW_wb<=RW_dm, RW_dm<=RW_ex, RW_ex<=(wr_rb ? rw_rb : 0).
- Non-writing or bubble instructions carry destination 0. R0 is never forwarded and never causes a stall.
- Forward select per used source s, computed combinationally from the pre-edge state and registered at the edge:
  - s==rw_rb && wr_rb && s!=0 -> 01
  - else s==RW_ex && s!=0 -> 10
  - else s==RW_dm && s!=0 -> 11
  - else 00
  - Youngest match wins. An unused source gives 00 (RB for classes 01 and 10).
- stall = in_valid && ld_rb && rw_rb!=0 && ((RA used && ra_in==rw_rb) || (RB used && rb_in==rw_rb)).
- Edge with in_valid && !stall: RA, RB, imm_sel, mux_sel_A/B, rw_rb, wr_rb, ld_rb load the new instruction; out_valid<=1.
- Edge with stall or !in_valid: bubble into the reg-bank stage. out_valid, wr_rb, ld_rb, mux_sels and imm_sel go to 0; RA/RB hold. The upstream stages keep shifting.
- A stall lasts exactly one cycle. The re-presented instruction then matches RW_ex and gets select 10 (ans_dm).
- we_wb is registered as (RW_dm!=0), so it tracks RW_wb!=0.
- Latency: decode inputs to reg-bank outputs is 1 cycle.
- Reset asserted mid-stream flushes all stages immediately. stall drops to 0 while rst is high.

Optional Feature:
- HFU_PERF_CNT_EN
- Defined: adds output stall_cnt[15:0], a saturating count of stall cycles (holds at 16'hFFFF), cleared by rst.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package mips_pkg holds:
  - class constants CLS_RALU=2'b00, CLS_IALU=2'b01, CLS_LOAD=2'b10, CLS_STORE=2'b11
  - forward-select constants FWD_REG=2'b00, FWD_EX=2'b01, FWD_DM=2'b10, FWD_WB=2'b11
  - REG_W and OPC_W defaults
- One sub-module, fwd_select: combinational comparator, one instance per source, producing the 2-bit select from s, used, rw_rb, wr_rb, RW_ex, RW_dm.

Test Plan:
- Reset: assert rst mid-run with in_valid=1 -> all outputs 0 immediately, asynchronously; after release, first valid instruction appears one cycle later.
- Back-to-back ALU: R-ALU rw=7, then R-ALU ra=7 rb=3 -> mux_sel_A=01, mux_sel_B=00; a third instruction ra=7 issued next cycle -> mux_sel_A=10.
- Distance 3: write r5, two unrelated instructions, then ra=5 -> mux_sel_A=11; a fourth-distance read of r5 -> 00.
- Load-use: LOAD rw=6, then R-ALU rb=6 -> stall=1 for exactly one cycle with a bubble (out_valid=0); next cycle mux_sel_B=10, out_valid=1.
- R0 and priority: write r0 then read r0 -> 00 and no stall. Write r4 twice consecutively, then read r4 -> 01 (youngest wins).
- Immediate/store: I-ALU ra=2 -> imm_sel=1, mux_sel_B=00. STORE ra=1 rb=7 following a write of r7 -> mux_sel_B=01, RW_ex=0 on the next edge, and we_wb=0 three cycles later.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and class helpers for the decode-side hazard/forward unit
package mips_pkg;

    localparam int REG_W = 5;
    localparam int OPC_W = 6;

    localparam logic [1:0] CLS_RALU  = 2'b00;
    localparam logic [1:0] CLS_IALU  = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_DM  = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Only R-ALU and STORE read the second source register.
    function automatic logic cls_uses_b(input logic [1:0] cls);
        return (cls == CLS_RALU) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - decode-side inputs and register-bank-side outputs of the hazard/forward unit
interface hazard_forward_unit_if #(
    parameter int REG_W = mips_pkg::REG_W,
    parameter int OPC_W = mips_pkg::OPC_W
);
    logic             in_valid;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] ra_in;
    logic [REG_W-1:0] rb_in;
    logic [REG_W-1:0] rw_in;
    logic             stall;
    logic             out_valid;
    logic [REG_W-1:0] RA;
    logic [REG_W-1:0] RB;
    logic             imm_sel;
    logic [1:0]       mux_sel_A;
    logic [1:0]       mux_sel_B;
    logic [REG_W-1:0] RW_ex;
    logic [REG_W-1:0] RW_dm;
    logic [REG_W-1:0] RW_wb;
    logic             we_wb;

    // Decoder / test driver side.
    modport master (
        output in_valid, opcode, ra_in, rb_in, rw_in,
        input  stall, out_valid, RA, RB, imm_sel, mux_sel_A, mux_sel_B,
        input  RW_ex, RW_dm, RW_wb, we_wb
    );

    // Hazard/forward unit side.
    modport slave (
        input  in_valid, opcode, ra_in, rb_in, rw_in,
        output stall, out_valid, RA, RB, imm_sel, mux_sel_A, mux_sel_B,
        output RW_ex, RW_dm, RW_wb, we_wb
    );
endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// rtl/hazard_forward_unit_fwd_select.sv - per-source forwarding select, youngest producer wins
module fwd_select #(
    parameter int REG_W = mips_pkg::REG_W
) (
    input  logic [REG_W-1:0] s,
    input  logic             used,
    input  logic [REG_W-1:0] rw_rb,
    input  logic             wr_rb,
    input  logic [REG_W-1:0] rw_ex,
    input  logic [REG_W-1:0] rw_dm,
    output logic [1:0]       sel
);
    import mips_pkg::*;

    // Check producers from youngest to oldest; R0 and unused sources read the register file.
    always_comb begin
        sel = FWD_REG;
        if (used && (s != '0)) begin
            if (wr_rb && (s == rw_rb)) begin
                sel = FWD_EX;
            end else if (s == rw_ex) begin
                sel = FWD_DM;
            end else if (s == rw_dm) begin
                sel = FWD_WB;
            end
        end
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - load-use stall, forwarding selects and destination tracking (optional HFU_PERF_CNT_EN stall counter)
module hazard_forward_unit #(
    parameter int REG_W = mips_pkg::REG_W,
    parameter int OPC_W = mips_pkg::OPC_W
) (
    input  logic clk,
    input  logic rst,
    hazard_forward_unit_if.slave bus
`ifdef HFU_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    import mips_pkg::*;

    logic [1:0]       cls;
    logic             use_b;
    logic             stall_c;
    logic [REG_W-1:0] rw_rb;
    logic             wr_rb;
    logic             ld_rb;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    assign cls   = bus.opcode[OPC_W-1 -: 2];
    assign use_b = cls_uses_b(cls);

    // A load in the reg-bank stage cannot forward yet; hold decode one cycle if its result is read.
    assign stall_c = !rst && bus.in_valid && ld_rb && (rw_rb != '0) &&
                     ((bus.ra_in == rw_rb) || (use_b && (bus.rb_in == rw_rb)));
    assign bus.stall = stall_c;

    fwd_select #(.REG_W(REG_W)) u_sel_a (
        .s     (bus.ra_in),
        .used  (1'b1),
        .rw_rb (rw_rb),
        .wr_rb (wr_rb),
        .rw_ex (bus.RW_ex),
        .rw_dm (bus.RW_dm),
        .sel   (sel_a)
    );

    fwd_select #(.REG_W(REG_W)) u_sel_b (
        .s     (bus.rb_in),
        .used  (use_b),
        .rw_rb (rw_rb),
        .wr_rb (wr_rb),
        .rw_ex (bus.RW_ex),
        .rw_dm (bus.RW_dm),
        .sel   (sel_b)
    );

    // Reg-bank stage load-or-bubble, plus the unconditional shift of destinations down the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.RA        <= '0;
            bus.RB        <= '0;
            bus.imm_sel   <= 1'b0;
            bus.mux_sel_A <= FWD_REG;
            bus.mux_sel_B <= FWD_REG;
            bus.RW_ex     <= '0;
            bus.RW_dm     <= '0;
            bus.RW_wb     <= '0;
            bus.we_wb     <= 1'b0;
            rw_rb         <= '0;
            wr_rb         <= 1'b0;
            ld_rb         <= 1'b0;
        end else begin
            bus.RW_wb <= bus.RW_dm;
            bus.RW_dm <= bus.RW_ex;
            bus.RW_ex <= wr_rb ? rw_rb : '0;
            bus.we_wb <= (bus.RW_dm != '0);
            if (bus.in_valid && !stall_c) begin
                bus.out_valid <= 1'b1;
                bus.RA        <= bus.ra_in;
                bus.RB        <= bus.rb_in;
                bus.imm_sel   <= (cls != CLS_RALU);
                bus.mux_sel_A <= sel_a;
                bus.mux_sel_B <= sel_b;
                rw_rb         <= bus.rw_in;
                wr_rb         <= (cls != CLS_STORE);
                ld_rb         <= (cls == CLS_LOAD);
            end else begin
                bus.out_valid <= 1'b0;
                bus.imm_sel   <= 1'b0;
                bus.mux_sel_A <= FWD_REG;
                bus.mux_sel_B <= FWD_REG;
                wr_rb         <= 1'b0;
                ld_rb         <= 1'b0;
            end
        end
    end

`ifdef HFU_PERF_CNT_EN
    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
